// File: rtl/score_pkg.sv
// score_pkg: shared BCD digit type, seven-segment codes and counter state encoding
package score_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {COUNTING, FULL} state_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: BCD digit to active-low seven-segment code (bit6..0 = g..a)
module seg7_encode
  import score_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);
  // Pure decode; non-BCD values turn every segment off
  always_comb
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
endmodule

// File: rtl/score_counter.sv
// score_counter: two-digit saturating BCD score counter with seven-segment outputs
module score_counter
  import score_pkg::*;
#(
  parameter int MAX_TENS = 9,
  parameter int MAX_ONES = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pass,
  input  logic       clear,
  input  logic       freeze,
  output bcd_t       ones,
  output bcd_t       tens,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       point,
  output logic       saturated
);
  localparam bcd_t SAT_T = bcd_t'(MAX_TENS);
  localparam bcd_t SAT_O = bcd_t'(MAX_ONES);
  state_t r_state;
  bcd_t   r_ones, r_tens;
  logic   r_pass_q, r_point, r_sat;
  logic   w_rise, w_inc, w_hit;
  bcd_t   w_ones_nx, w_tens_nx;
  assign w_rise    = pass & ~r_pass_q;
  assign w_inc     = w_rise & ~freeze & (r_state == COUNTING) & ~clear;
  assign w_ones_nx = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
  assign w_tens_nx = (r_ones == 4'd9) ? r_tens + 4'd1 : r_tens;
  assign w_hit     = (w_tens_nx == SAT_T) && (w_ones_nx == SAT_O);
  // Edge detect, BCD count, point pulse and COUNTING/FULL state; pass_q resets high so a held pass never scores
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pass_q <= 1'b1;
      r_ones   <= '0;
      r_tens   <= '0;
      r_point  <= 1'b0;
      r_sat    <= 1'b0;
      r_state  <= COUNTING;
    end else begin
      r_pass_q <= pass;
      r_point  <= w_inc;
      if (clear) begin
        r_ones  <= '0;
        r_tens  <= '0;
        r_sat   <= 1'b0;
        r_state <= COUNTING;
      end else if (w_inc) begin
        r_ones <= w_ones_nx;
        r_tens <= w_tens_nx;
        if (w_hit) begin
          r_sat   <= 1'b1;
          r_state <= FULL;
        end
      end
    end
  assign ones      = r_ones;
  assign tens      = r_tens;
  assign point     = r_point;
  assign saturated = r_sat;
  seg7_encode u_seg_ones (.i_bcd(r_ones), .o_seg(HEX0));
  seg7_encode u_seg_tens (.i_bcd(r_tens), .o_seg(HEX1));
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: scoreboard bench for score_counter with directed stimulus
module tb_score_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pass = 1'b0;
  logic       clear = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] ones, tens;
  logic [6:0] HEX0, HEX1;
  logic       point, saturated;

  score_counter dut (
    .clk(clk), .reset(reset), .pass(pass), .clear(clear), .freeze(freeze),
    .ones(ones), .tens(tens), .HEX0(HEX0), .HEX1(HEX1),
    .point(point), .saturated(saturated)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int n_pts = 0;
  int m_score = 0;
  int m_prev = 1;
  int m_sat = 0;
  int pts_before;
  int e;
  logic prev_point = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_score(input string name, input int t, input int o);
    chk(name, int'(tens) * 10 + int'(ones), t * 10 + o);
  endtask

  // Monitor: each point pulse pops the next expected score and checks digits, HEX codes and saturation
  always @(negedge clk) begin
    if (point) begin
      n_pts++;
      chk("point_back_to_back", int'(prev_point), 0);
      if (exp_q.size() == 0) chk("unexpected_point", int'(point), 0);
      else begin
        e = exp_q.pop_front();
        chk("mon_score", int'(tens) * 10 + int'(ones), e);
        chk("mon_hex0", int'(HEX0), int'(seg_tab[e % 10]));
        chk("mon_hex1", int'(HEX1), int'(seg_tab[e / 10]));
        chk("mon_sat", int'(saturated), (e == 99) ? 1 : 0);
      end
    end
    prev_point = point;
  end

  task automatic cyc(input logic p, input logic c, input logic f);
    logic inc;
    pass = p;
    clear = c;
    freeze = f;
    inc = p && (m_prev == 0) && !f && (m_sat == 0) && !c;
    if (inc) exp_q.push_back(m_score + 1);
    @(posedge clk);
    #1;
    m_prev = int'(p);
    if (c) begin
      m_score = 0;
      m_sat = 0;
    end else if (inc) begin
      m_score++;
      m_sat = (m_score == 99) ? 1 : 0;
    end
  endtask

  task automatic edges(input int n, input logic f);
    repeat (n) begin
      cyc(1'b1, 1'b0, f);
      cyc(1'b0, 1'b0, f);
    end
  endtask

  task automatic model_reset();
    m_score = 0;
    m_prev = 1;
    m_sat = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_score("reset_score", 0, 0);
    chk("reset_hex0", int'(HEX0), 'b1000000);
    chk("reset_hex1", int'(HEX1), 'b1000000);
    chk("reset_point", int'(point), 0);
    chk("reset_sat", int'(saturated), 0);
    reset = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
    end
    chk_score("three_pulses", 0, 3);
    chk("three_hex0", int'(HEX0), 'b0110000);
    chk("three_hex1", int'(HEX1), 'b1000000);
    chk("three_points", n_pts, 3);
    cyc(1'b0, 1'b1, 1'b0);
    edges(9, 1'b0);
    chk_score("nine", 0, 9);
    edges(1, 1'b0);
    chk_score("ten", 1, 0);
    chk("ten_hex1", int'(HEX1), 'b1111001);
    chk("ten_hex0", int'(HEX0), 'b1000000);
    edges(89, 1'b0);
    chk_score("reach_99", 9, 9);
    chk("sat_high", int'(saturated), 1);
    pts_before = n_pts;
    edges(5, 1'b0);
    chk_score("hold_99", 9, 9);
    chk("sat_no_points", n_pts - pts_before, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_score("clear_from_99", 0, 0);
    chk("sat_cleared", int'(saturated), 0);
    edges(12, 1'b0);
    chk_score("twelve", 1, 2);
    pts_before = n_pts;
    edges(4, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk_score("freeze_hold", 1, 2);
    chk("freeze_no_points", n_pts - pts_before, 0);
    cyc(1'b0, 1'b0, 1'b0);
    edges(1, 1'b0);
    chk_score("after_freeze", 1, 3);
    cyc(1'b0, 1'b1, 1'b0);
    edges(7, 1'b0);
    chk_score("seven", 0, 7);
    cyc(1'b1, 1'b1, 1'b0);
    chk_score("clear_beats_rise", 0, 0);
    chk("clear_point", int'(point), 0);
    cyc(1'b0, 1'b0, 1'b0);
    pass = 1'b1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pts_before = n_pts;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk_score("held_pass_reset", 0, 0);
    chk("held_pass_points", n_pts - pts_before, 0);
    cyc(1'b0, 1'b0, 1'b0);
    edges(45, 1'b0);
    chk_score("forty_five", 4, 5);
    reset = 1'b1;
    #2;
    chk_score("async_score", 0, 0);
    chk("async_hex0", int'(HEX0), 'b1000000);
    chk("async_hex1", int'(HEX1), 'b1000000);
    chk("async_sat", int'(saturated), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    edges(2, 1'b0);
    chk_score("after_async", 0, 2);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
